encoder_quad_decoder: RTL and testbench
=======================================

# encoder_quad_decoder

Quadrature encoder front end for the PWM control path. Takes the raw two-phase encoder pins, synchronises and filters them, decodes x4 quadrature transitions into detent steps, and keeps a saturating 8-bit position (0..POS_MAX). That position is the PWM set-point source for the control stage, which takes an 8-bit encoder value today driven from simulation switches.

## Interface
- FILTER_CYCLES, 1000 — consecutive stable clocks required before a filtered channel changes (20 µs at 50 MHz); legal range 1..65535.
- POS_MAX, 100 — upper saturation limit of POSICION; legal range 1..255.
- CLK  input  1  system clock, all logic on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- ENCODER  input  2  raw encoder pins, asynchronous; ENCODER[1] = A, ENCODER[0] = B.
- CLEAR  input  1  synchronous clear of position, sub-count and error.
- POSICION  output  8  current position, 0..POS_MAX.
- STEP  output  1  one-cycle pulse whenever POSICION changes.
- DIR  output  1  direction of the last accepted detent: 1 = up (CW), 0 = down.
- ERROR  output  1  sticky flag for an illegal quadrature transition (A and B change together).

## Operation
- Each ENCODER bit passes through a 2-flop synchroniser; synchroniser flops reset to 0.
- Filter, per channel: a counter increments while the synchronised value differs from the filtered value and clears when they match. When the counter reaches FILTER_CYCLES, the filtered value takes the synchronised value and the counter clears. Filtered values reset to 0.
- State machine:
  - INIT (reset state): on the first clock after reset, load PREV with the filtered {A,B}, then go to TRACK. No counting happens in INIT.
  - TRACK: compare the filtered {A,B} with PREV every clock, then load PREV.
- Transition decode ({A,B}):
  - 00→01→11→10→00 gives sub-count +1.
  - The reverse sequence gives sub-count −1.
  - No change: nothing happens.
  - Both bits change: ERROR is set, sub-count clears to 0, position is unchanged.
- Sub-count is a signed 3-bit value, −3..+3.
  - Reaching +4 is a detent up: the sub-count clears and DIR is set to 1.
  - Reaching −4 is a detent down: the sub-count clears and DIR is set to 0.
- Position update:
  - Detent up with POSICION < POS_MAX: POSICION increments and STEP pulses.
  - Detent down with POSICION > 0: POSICION decrements and STEP pulses.
  - At a saturation limit, POSICION holds and STEP stays 0, but DIR still updates.
- CLEAR sets POSICION = 0, sub-count = 0 and ERROR = 0. It takes priority over a detent in the same cycle, and then there is no STEP. PREV is still loaded, so the current phase becomes the new reference.
- ERROR stays set until CLEAR or reset.

## Timing
- Reset values: POSICION = 0, STEP = 0, DIR = 0, ERROR = 0, state = INIT, sub-count = 0, filter counters = 0.
- Latency from a raw pin edge (held stable) to the filtered change: 2 + FILTER_CYCLES clocks.
- A filtered transition completing a detent updates POSICION and asserts STEP on the next rising edge. STEP is high for exactly one clock.
- Input glitches shorter than FILTER_CYCLES clocks produce no filtered change.
- Reset mid-operation: all outputs return to their reset values asynchronously, and the next detent after release requires a full 4-transition sequence from the phase sampled in INIT.
- Both channels changing within the same filtered clock counts as illegal, even if the raw edges were separated.

## Configuration
- ENCODER_FILTRO_EN defined: the filter is instantiated as described above.
- Not defined: the filter is removed, the filtered value equals the synchronised value, FILTER_CYCLES is ignored, and the latency from pin to filtered value is 2 clocks.

## Test plan
- Reset, then 4 clean CW transitions (00→01→11→10→00), each held 1200 clocks → POSICION 0→1, one STEP pulse, DIR = 1, ERROR = 0.
- 120 CW detents from 0 with POS_MAX = 100 → POSICION stops at 100, exactly 100 STEP pulses. Then 1 CCW detent → POSICION = 99, DIR = 0.
- A channel glitch of 500 clocks with FILTER_CYCLES = 1000 → no change to POSICION, STEP or sub-count. Without ENCODER_FILTRO_EN, the same glitch advances the sub-count, and 4 such glitched transitions give a detent.
- Filtered {A,B} 00→11 → ERROR = 1, sub-count = 0, POSICION unchanged. ERROR stays set through 2 subsequent legal detents and clears on a CLEAR pulse.
- CLEAR asserted in the same cycle as the 4th transition of a CW detent with POSICION = 50 → POSICION = 0, no STEP.
- RST_N low for 3 clocks midway through a detent at POSICION = 7 → all outputs return to reset values immediately. After release, 2 further transitions produce no STEP.

Source files
------------

// File: rtl/encoder_quad_decoder.sv
// Quadrature encoder front end: sync, optional glitch filter (ENCODER_FILTRO_EN),
// x4 decode into detents and a saturating 0..POS_MAX position.
module encoder_quad_decoder #(
   parameter int unsigned FILTER_CYCLES = 1000,
   parameter int unsigned POS_MAX       = 100
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [1:0] ENCODER,
   input  logic       CLEAR,
   output logic [7:0] POSICION,
   output logic       STEP,
   output logic       DIR,
   output logic       ERROR
);

   if (FILTER_CYCLES < 1 || FILTER_CYCLES > 65535 ||
       POS_MAX < 1 || POS_MAX > 255) begin : g_bad_param
      $error("encoder_quad_decoder: parameter out of range");
   end

   typedef enum logic {INIT, TRACK} state_t;

   localparam logic [7:0]        PMAX    = 8'(POS_MAX);
   localparam logic signed [2:0] SUB_MAX = 3'sd3;
   localparam logic signed [2:0] SUB_MIN = -3'sd3;

   logic [1:0] sync1_q, sync1_d;
   logic [1:0] sync2_q, sync2_d;
   logic [1:0] filt;

   always_comb begin
      sync1_d = ENCODER;
      sync2_d = sync1_q;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

`ifdef ENCODER_FILTRO_EN
   localparam logic [15:0] CNT_LAST = 16'(FILTER_CYCLES - 1);

   logic [1:0][15:0] cnt_q, cnt_d;
   logic [1:0]       filt_q, filt_d;

   always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != filt_q[i]) begin
            if (cnt_q[i] == CNT_LAST) filt_d[i] = sync2_q[i];
            else                      cnt_d[i]  = cnt_q[i] + 16'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q  <= '0;
         filt_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign filt = filt_q;
`else
   assign filt = sync2_q;
`endif

   state_t            state_q, state_d;
   logic [1:0]        prev_q, prev_d;
   logic signed [2:0] sub_q, sub_d;
   logic [7:0]        pos_q, pos_d;
   logic              step_q, step_d;
   logic              dir_q, dir_d;
   logic              err_q, err_d;
   logic [1:0]        delta;
   logic              det_up, det_dn;

   // Gray phase to ring index: 00,01,11,10 -> 0,1,2,3
   assign delta = {filt[1], ^filt} - {prev_q[1], ^prev_q};

   always_comb begin
      state_d = state_q;
      prev_d  = filt;
      sub_d   = sub_q;
      pos_d   = pos_q;
      step_d  = 1'b0;
      dir_d   = dir_q;
      err_d   = err_q;
      det_up  = 1'b0;
      det_dn  = 1'b0;
      unique case (state_q)
         INIT: state_d = TRACK;
         TRACK: begin
            unique case (delta)
               2'd1: begin
                  if (sub_q == SUB_MAX) det_up = 1'b1;
                  else                  sub_d  = sub_q + 3'sd1;
               end
               2'd3: begin
                  if (sub_q == SUB_MIN) det_dn = 1'b1;
                  else                  sub_d  = sub_q - 3'sd1;
               end
               2'd2: begin
                  err_d = 1'b1;
                  sub_d = '0;
               end
               default: ;
            endcase
         end
         default: state_d = INIT;
      endcase
      if (det_up) begin
         sub_d = '0;
         dir_d = 1'b1;
         if (pos_q < PMAX) begin
            pos_d  = pos_q + 8'd1;
            step_d = 1'b1;
         end
      end
      if (det_dn) begin
         sub_d = '0;
         dir_d = 1'b0;
         if (pos_q != 8'd0) begin
            pos_d  = pos_q - 8'd1;
            step_d = 1'b1;
         end
      end
      if (CLEAR) begin
         pos_d  = '0;
         sub_d  = '0;
         err_d  = 1'b0;
         step_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= INIT;
         prev_q  <= '0;
         sub_q   <= '0;
         pos_q   <= '0;
         step_q  <= 1'b0;
         dir_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         sub_q   <= sub_d;
         pos_q   <= pos_d;
         step_q  <= step_d;
         dir_q   <= dir_d;
         err_q   <= err_d;
      end
   end

   assign POSICION = pos_q;
   assign STEP     = step_q;
   assign DIR      = dir_q;
   assign ERROR    = err_q;

endmodule

// File: tb/tb_encoder_quad_decoder.sv
// Directed bench for encoder_quad_decoder with a short filter window.
// Expectations adapt to whether ENCODER_FILTRO_EN is defined.
module tb_encoder_quad_decoder;

   localparam int F    = 4;
   localparam int PMAX = 100;
   localparam int HOLD = 8;
`ifdef ENCODER_FILTRO_EN
   localparam int LAT  = 3 + F;
   localparam bit FILT = 1'b1;
`else
   localparam int LAT  = 3;
   localparam bit FILT = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST_N;
   logic [1:0] ENCODER;
   logic       CLEAR;
   logic [7:0] POSICION;
   logic       STEP;
   logic       DIR;
   logic       ERROR;

   int err_cnt   = 0;
   int chk_cnt   = 0;
   int step_cnt  = 0;
   int exp_steps = 0;
   int idx       = 0;

   encoder_quad_decoder #(
      .FILTER_CYCLES(F),
      .POS_MAX      (PMAX)
   ) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .ENCODER (ENCODER),
      .CLEAR   (CLEAR),
      .POSICION(POSICION),
      .STEP    (STEP),
      .DIR     (DIR),
      .ERROR   (ERROR)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) if (STEP === 1'b1) step_cnt++;

   task automatic check(input string tag, input int obs, input int exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] seq(input int i);
      case (i & 3)
         0: return 2'b00;
         1: return 2'b01;
         2: return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   task automatic put(input logic [1:0] ab, input int n);
      ENCODER = ab;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic cw(input int n);
      for (int k = 0; k < n; k++) begin
         idx = (idx + 1) & 3;
         put(seq(idx), HOLD);
      end
   endtask

   task automatic ccw(input int n);
      for (int k = 0; k < n; k++) begin
         idx = (idx + 3) & 3;
         put(seq(idx), HOLD);
      end
   endtask

   task automatic pulse_clear();
      CLEAR = 1'b1;
      @(posedge CLK);
      #1;
      CLEAR = 1'b0;
   endtask

   initial begin
      RST_N   = 1'b0;
      ENCODER = 2'b00;
      CLEAR   = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_pos", POSICION, 0);
      check("rst_step", STEP, 0);
      check("rst_dir", DIR, 0);
      check("rst_err", ERROR, 0);
      RST_N = 1'b1;
      repeat (3) @(posedge CLK);
      #1;

      cw(4);
      exp_steps += 1;
      check("cw1_pos", POSICION, 1);
      check("cw1_steps", step_cnt, exp_steps);
      check("cw1_dir", DIR, 1);
      check("cw1_err", ERROR, 0);
      check("cw1_step_low", STEP, 0);

      pulse_clear();
      check("clr_pos", POSICION, 0);
      cw(480);
      exp_steps += 100;
      check("sat_pos", POSICION, 100);
      check("sat_steps", step_cnt, exp_steps);
      check("sat_dir", DIR, 1);
      ccw(4);
      exp_steps += 1;
      check("ccw_pos", POSICION, 99);
      check("ccw_dir", DIR, 0);
      check("ccw_steps", step_cnt, exp_steps);

      put(2'b01, 2);
      put(2'b00, 10);
      check("glitch_pos", POSICION, 99);
      check("glitch_steps", step_cnt, exp_steps);
      put(2'b01, 1);
      put(2'b11, 1);
      put(2'b10, 1);
      put(2'b00, 12);
      if (!FILT) exp_steps += 1;
      check("fast_pos", POSICION, FILT ? 99 : 100);
      check("fast_steps", step_cnt, exp_steps);

      pulse_clear();
      put(2'b11, HOLD);
      idx = 2;
      check("ill_err", ERROR, 1);
      check("ill_pos", POSICION, 0);
      check("ill_steps", step_cnt, exp_steps);
      cw(8);
      exp_steps += 2;
      check("ill_det_pos", POSICION, 2);
      check("ill_det_err", ERROR, 1);
      check("ill_det_steps", step_cnt, exp_steps);
      pulse_clear();
      check("ill_clr_err", ERROR, 0);
      check("ill_clr_pos", POSICION, 0);

      cw(200);
      exp_steps += 50;
      check("p50_pos", POSICION, 50);
      cw(3);
      idx = (idx + 1) & 3;
      ENCODER = seq(idx);
      repeat (LAT - 1) @(posedge CLK);
      #1;
      CLEAR = 1'b1;
      @(posedge CLK);
      #1;
      CLEAR = 1'b0;
      check("cd_step_low", STEP, 0);
      repeat (4) @(posedge CLK);
      #1;
      check("cd_pos", POSICION, 0);
      check("cd_steps", step_cnt, exp_steps);

      cw(28);
      exp_steps += 7;
      check("p7_pos", POSICION, 7);
      check("p7_steps", step_cnt, exp_steps);
      cw(1);
      RST_N = 1'b0;
      #1;
      check("mr_pos", POSICION, 0);
      check("mr_step", STEP, 0);
      check("mr_dir", DIR, 0);
      check("mr_err", ERROR, 0);
      repeat (3) @(posedge CLK);
      #1;
      RST_N = 1'b1;
      repeat (HOLD + 2) @(posedge CLK);
      #1;
      cw(2);
      check("mr_after_steps", step_cnt, exp_steps);
      check("mr_after_pos", POSICION, 0);
      check("mr_after_err", ERROR, 0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
